// File: rtl/mux_2to1.sv
// mux_2to1: parameterised-width 2:1 multiplexer with a zero-latency
// combinational output, a registered copy with valid flag, and a
// saturating counter of select changes.
// Optional build macro: MUX_2TO1_PARITY_EN adds a registered parity
// output y_par (XOR-reduction of the captured data).
module mux_2to1 #(
  parameter int W     = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic [W-1:0]     d0,
  input  logic [W-1:0]     d1,
  input  logic             en,
  output logic [W-1:0]     y,
  output logic [W-1:0]     y_q,
  output logic             y_vld,
`ifdef MUX_2TO1_PARITY_EN
  output logic             y_par,
`endif
  output logic [CNT_W-1:0] sw_cnt
);

  logic [W-1:0]     w_sel;
  logic             w_sw;
  logic             w_sat;

  logic [W-1:0]     r_y_q;
  logic             r_y_vld;
  logic             r_s_prev;
  logic [CNT_W-1:0] r_sw_cnt;

  // Selected data; shared by the zero-latency output and the capture path.
  always_comb begin
    w_sel = s ? d1 : d0;
  end

  // A select change is any difference from last cycle's sampled select;
  // the counter stops at all-ones so it never wraps back to a small value.
  assign w_sw  = (s != r_s_prev);
  assign w_sat = (r_sw_cnt == {CNT_W{1'b1}});

  // Capture the selected value when enabled; reset discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q   <= '0;
      r_y_vld <= 1'b0;
    end else if (en) begin
      r_y_q   <= w_sel;
      r_y_vld <= 1'b1;
    end
  end

  // Track the previous select every cycle, independent of the capture enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_prev <= 1'b0;
    end else begin
      r_s_prev <= s;
    end
  end

  // Count select changes, holding once the counter reaches its maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_cnt <= '0;
    end else if (w_sw && !w_sat) begin
      r_sw_cnt <= r_sw_cnt + 1'b1;
    end
  end

`ifdef MUX_2TO1_PARITY_EN
  logic r_y_par;

  // Parity of the selected data, captured under the same enable as y_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_par <= 1'b0;
    end else if (en) begin
      r_y_par <= ^w_sel;
    end
  end

  assign y_par = r_y_par;
`endif

  assign y      = w_sel;
  assign y_q    = r_y_q;
  assign y_vld  = r_y_vld;
  assign sw_cnt = r_sw_cnt;

endmodule

// File: tb/tb_mux_2to1.sv
// Bench for mux_2to1: a W=1 instance for the exhaustive truth table and a
// W=8 / CNT_W=2 instance for the registered path, asynchronous reset,
// counter saturation and (when MUX_2TO1_PARITY_EN is defined) parity.
module tb_mux_2to1;

  logic clk;

  // W=1 instance, reset held low, capture disabled.
  logic       s1, d0_1, d1_1, rst1, en1;
  logic       y1, yq1, yvld1;
  logic [7:0] cnt1;

  // W=8, CNT_W=2 instance.
  logic       s8, rst8, en8;
  logic [7:0] d0_8, d1_8, y8, yq8;
  logic       yvld8;
  logic [1:0] cnt8;
`ifdef MUX_2TO1_PARITY_EN
  logic       par1, par8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  mux_2to1 #(.W(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst1), .s(s1), .d0(d0_1), .d1(d1_1), .en(en1),
    .y(y1), .y_q(yq1), .y_vld(yvld1),
`ifdef MUX_2TO1_PARITY_EN
    .y_par(par1),
`endif
    .sw_cnt(cnt1)
  );

  mux_2to1 #(.W(8), .CNT_W(2)) u_w8 (
    .clk(clk), .rst(rst8), .s(s8), .d0(d0_8), .d1(d1_8), .en(en8),
    .y(y8), .y_q(yq8), .y_vld(yvld8),
`ifdef MUX_2TO1_PARITY_EN
    .y_par(par8),
`endif
    .sw_cnt(cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record an expectation at the moment the stimulus is driven.
  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows.
  task automatic check(input logic [31:0] observed);
    logic [31:0] expected;
    string       tag;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty observed=%0h expected=none", observed);
    end else begin
      expected = exp_q.pop_front();
      tag      = tag_q.pop_front();
      assert (observed === expected) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
    end
  endtask

  logic [7:0] tt_vec;
  logic [7:0] tt_req;
  logic [1:0] sat_req [5];

  initial begin
    tt_req     = 8'b1010_1100;  // bit i = required y for vector i: 0,0,1,1,0,1,0,1
    sat_req[0] = 2'd1;
    sat_req[1] = 2'd2;
    sat_req[2] = 2'd3;
    sat_req[3] = 2'd3;
    sat_req[4] = 2'd3;

    rst1 = 1'b0; en1 = 1'b0; s1 = 1'b0; d0_1 = 1'b0; d1_1 = 1'b0;
    rst8 = 1'b1; en8 = 1'b0; s8 = 1'b0; d0_8 = 8'h00; d1_8 = 8'h00;

    // Exhaustive truth table, (s,d0,d1) = 000 .. 111 at 10-unit steps.
    for (int i = 0; i < 8; i++) begin
      tt_vec = 8'(i);
      s1   = tt_vec[2];
      d0_1 = tt_vec[1];
      d1_1 = tt_vec[0];
      push($sformatf("truth_%0d%0d%0d", tt_vec[2], tt_vec[1], tt_vec[0]), {31'd0, tt_req[i]});
      #1 check({31'd0, y1});
      #9;
    end

    // Reset state of the W=8 instance.
    push("rst_y_q", 32'h00);    check({24'd0, yq8});
    push("rst_y_vld", 32'h0);   check({31'd0, yvld8});
    push("rst_sw_cnt", 32'h0);  check({30'd0, cnt8});

    // Registered path: capture d1.
    @(negedge clk);
    rst8 = 1'b0; d0_8 = 8'h5A; d1_8 = 8'hA5; s8 = 1'b1; en8 = 1'b1;
    push("cap_y_q", 32'hA5);
    push("cap_y_vld", 32'h1);
    push("cap_sw_cnt", 32'h1);
    @(posedge clk); #1;
    check({24'd0, yq8}); check({31'd0, yvld8}); check({30'd0, cnt8});

    // en=0, s=0: y follows immediately, y_q holds.
    @(negedge clk);
    en8 = 1'b0; s8 = 1'b0;
    push("hold_y_comb", 32'h5A);
    #1 check({24'd0, y8});
    push("hold_y_q", 32'hA5);
    push("hold_y_vld", 32'h1);
    push("hold_sw_cnt", 32'h2);
    @(posedge clk); #1;
    check({24'd0, yq8}); check({31'd0, yvld8}); check({30'd0, cnt8});

    // Asynchronous reset between edges.
    #2 rst8 = 1'b1;
    push("arst_y_q", 32'h00);
    push("arst_y_vld", 32'h0);
    push("arst_sw_cnt", 32'h0);
    push("arst_y", 32'h5A);
    #1;
    check({24'd0, yq8}); check({31'd0, yvld8}); check({30'd0, cnt8}); check({24'd0, y8});
    @(negedge clk);
    s8 = 1'b1;
    push("arst_y_s1", 32'hA5);
    #1 check({24'd0, y8});

    // Release reset with en=0 and s=0: nothing captured, no select change.
    @(negedge clk);
    rst8 = 1'b0; s8 = 1'b0;
    push("post_rst_y_vld", 32'h0);
    push("post_rst_y_q", 32'h00);
    push("post_rst_sw_cnt", 32'h0);
    @(posedge clk); #1;
    check({31'd0, yvld8}); check({24'd0, yq8}); check({30'd0, cnt8});

    // Toggle s on 5 consecutive edges; CNT_W=2 saturates at 3.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      s8 = ~s8;
      push($sformatf("sat_toggle_%0d", k), {30'd0, sat_req[k]});
      @(posedge clk); #1;
      check({30'd0, cnt8});
    end

    // Hold s constant: count unchanged.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      push($sformatf("sat_hold_%0d", k), 32'h3);
      @(posedge clk); #1;
      check({30'd0, cnt8});
    end

    // Capture 0x07 via d1 (s already 1), then 0x03 via d0.
    @(negedge clk);
    d1_8 = 8'h07; s8 = 1'b1; en8 = 1'b1;
    push("par_a_y_q", 32'h07);
`ifdef MUX_2TO1_PARITY_EN
    push("par_a_y_par", 32'h1);
`endif
    @(posedge clk); #1;
    check({24'd0, yq8});
`ifdef MUX_2TO1_PARITY_EN
    check({31'd0, par8});
`endif

    @(negedge clk);
    d0_8 = 8'h03; s8 = 1'b0; en8 = 1'b1;
    push("par_b_y_q", 32'h03);
`ifdef MUX_2TO1_PARITY_EN
    push("par_b_y_par", 32'h0);
`endif
    @(posedge clk); #1;
    check({24'd0, yq8});
`ifdef MUX_2TO1_PARITY_EN
    check({31'd0, par8});
`endif

    // Every pushed expectation must have been consumed.
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
